// File: rtl/k2_pkg.sv
// Shared types and constants for the K2 program loader.
// Frame start marker and loader FSM state encoding.
package k2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    LO,
    HI,
    CHECK,
    RUN,
    ERROR
  } loader_state_t;

  localparam logic [7:0] LOADER_START_BYTE = 8'hA5;

  function automatic logic is_loading(loader_state_t s);
    return (s == IDLE) || (s == COUNT) || (s == LO) ||
           (s == HI) || (s == CHECK);
  endfunction

endpackage

// File: rtl/k2_instr_mem.sv
// Instruction store: one synchronous write port, async read.
// Whole array clears on rst_n so a reset never leaves a stale program.
module k2_instr_mem #(
  parameter int INST_W = 10,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [INST_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [INST_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [INST_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '{default: '0};
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/k2_program_loader.sv
// UART boot loader for K2: parses A5/N/{lo,hi}*N/CHK frames into
// the instruction store and holds the CPU in reset until the checksum matches.
module k2_program_loader
  import k2_pkg::*;
#(
  parameter int INST_W  = 10,
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              rx_correct,
  input  logic              load_req,
  input  logic [ADDR_W-1:0] ProgramAddress,
  output logic [INST_W-1:0] instruction_data,
  output logic              cpu_rst_n,
  output logic              loading,
  output logic              load_error
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int TW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 2;
  localparam int NW    = ADDR_W + 1;

  loader_state_t     state, nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [NW-1:0]     n_q;
  logic [7:0]        xor_q;
  logic [7:0]        lo_q;
  logic [TW-1:0]     tmo_q;
  logic              acc;
  logic              last;
  logic              active;
  logic              we;
  logic [INST_W-1:0] wdata;

  assign acc    = !load_req && rx_valid && rx_correct;
  assign last   = ({1'b0, addr_q} == n_q - NW'(1));
  assign active = is_loading(state) && (state != IDLE);
  assign we     = acc && (state == HI);
  assign wdata  = INST_W'({rx_data[1:0], lo_q});

  always_comb begin
    nxt = state;
    if (load_req) begin
      nxt = IDLE;
    end else if (rx_valid) begin
      unique case (state)
        IDLE: begin
          if (rx_correct && rx_data == LOADER_START_BYTE)
            nxt = COUNT;
        end
        COUNT: begin
          if (!rx_correct || rx_data == 8'd0 ||
              rx_data > 8'(DEPTH))
            nxt = ERROR;
          else
            nxt = LO;
        end
        LO:    nxt = rx_correct ? HI : ERROR;
        HI:    nxt = !rx_correct ? ERROR : (last ? CHECK : LO);
        CHECK: nxt = (rx_correct && rx_data == xor_q) ? RUN : ERROR;
        RUN, ERROR: nxt = state;
        default: nxt = ERROR;
      endcase
    end else if (active && tmo_q == TW'(TIMEOUT - 1)) begin
      nxt = ERROR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr_q     <= '0;
      n_q        <= '0;
      xor_q      <= '0;
      lo_q       <= '0;
      tmo_q      <= '0;
      cpu_rst_n  <= 1'b0;
      loading    <= 1'b1;
      load_error <= 1'b0;
    end else begin
      state      <= nxt;
      cpu_rst_n  <= (nxt == RUN);
      loading    <= is_loading(nxt);
      load_error <= (nxt == ERROR);
      if (nxt != state || rx_valid || !active)
        tmo_q <= '0;
      else
        tmo_q <= tmo_q + TW'(1);
      if (acc) begin
        unique case (state)
          COUNT: begin
            n_q    <= rx_data[NW-1:0];
            addr_q <= '0;
            xor_q  <= '0;
          end
          LO: begin
            lo_q  <= rx_data;
            xor_q <= xor_q ^ rx_data;
          end
          HI: begin
            xor_q <= xor_q ^ rx_data;
            if (!last)
              addr_q <= addr_q + ADDR_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

  k2_instr_mem #(
    .INST_W(INST_W),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (we),
    .waddr(addr_q),
    .wdata(wdata),
    .raddr(ProgramAddress),
    .rdata(instruction_data)
  );

endmodule

// File: tb/tb_k2_program_loader.sv
// Directed bench for k2_program_loader with a short timeout.
// Each step drives bytes and checks outputs against hand-computed values.
module tb_k2_program_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_correct = 1'b0;
  logic       load_req = 1'b0;
  logic [3:0] ProgramAddress = 4'd0;
  logic [9:0] instruction_data;
  logic       cpu_rst_n;
  logic       loading;
  logic       load_error;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  k2_program_loader #(
    .INST_W (10),
    .ADDR_W (4),
    .TIMEOUT(16)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rx_valid        (rx_valid),
    .rx_data         (rx_data),
    .rx_correct      (rx_correct),
    .load_req        (load_req),
    .ProgramAddress  (ProgramAddress),
    .instruction_data(instruction_data),
    .cpu_rst_n       (cpu_rst_n),
    .loading         (loading),
    .load_error      (load_error)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic ok = 1'b1);
    @(negedge clk);
    rx_valid   = 1'b1;
    rx_data    = b;
    rx_correct = ok;
    @(negedge clk);
    rx_valid   = 1'b0;
    rx_correct = 1'b0;
  endtask

  task automatic req();
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input string tag,
                    input logic [9:0] exp);
    ProgramAddress = a;
    #1;
    check(tag, {22'd0, instruction_data}, {22'd0, exp});
  endtask

  initial begin
    logic [9:0] w;
    logic [7:0] hb;
    logic [7:0] chk;

    // 1: reset values, then a two-word load
    repeat (2) @(negedge clk);
    check("rst_loading", loading, 1);
    check("rst_error", load_error, 0);
    check("rst_cpu", cpu_rst_n, 0);
    rd(4'd0, "rst_mem0", 10'h000);
    rst_n = 1'b1;
    send(8'hA5); send(8'h02);
    send(8'h34); send(8'h01);
    send(8'hC7); send(8'h02);
    check("pre_chk_cpu", cpu_rst_n, 0);
    send(8'hF0);
    check("t1_cpu", cpu_rst_n, 1);
    check("t1_loading", loading, 0);
    rd(4'd0, "t1_mem0", 10'h134);
    rd(4'd1, "t1_mem1", 10'h2C7);
    send(8'hA5);
    check("run_ignores", loading, 0);

    // 2: bad checksum
    req();
    check("t2_req_loading", loading, 1);
    check("t2_req_cpu", cpu_rst_n, 0);
    send(8'hA5); send(8'h01); send(8'h55); send(8'h00);
    send(8'h54);
    check("t2_error", load_error, 1);
    check("t2_cpu", cpu_rst_n, 0);
    rd(4'd0, "t2_mem0", 10'h055);
    rd(4'd1, "t2_mem1", 10'h2C7);
    req();
    check("t2_idle_loading", loading, 1);
    check("t2_idle_error", load_error, 0);

    // 3: N out of range
    send(8'hA5); send(8'h00);
    check("t3_n0_error", load_error, 1);
    req();
    send(8'hA5); send(8'h11);
    check("t3_n17_error", load_error, 1);
    rd(4'd0, "t3_mem0", 10'h055);
    rd(4'd1, "t3_mem1", 10'h2C7);

    // 4: inter-byte timeout, then IDLE noise
    req();
    send(8'hA5); send(8'h01);
    repeat (15) @(negedge clk);
    check("t4_before_tmo", load_error, 0);
    @(negedge clk);
    check("t4_tmo", load_error, 1);
    req();
    send(8'h3C); send(8'h7E);
    repeat (30) @(negedge clk);
    check("t4_noise_loading", loading, 1);
    check("t4_noise_error", load_error, 0);

    // 5: parity error, then load_req racing a byte in RUN
    send(8'hA5); send(8'h01); send(8'h12, 1'b0);
    check("t5_parity", load_error, 1);
    req();
    send(8'hA5); send(8'h01); send(8'h12); send(8'h03);
    send(8'h11);
    check("t5_run", cpu_rst_n, 1);
    rd(4'd0, "t5_mem0", 10'h312);
    @(negedge clk);
    load_req = 1'b1; rx_valid = 1'b1;
    rx_data = 8'hA5; rx_correct = 1'b1;
    @(negedge clk);
    load_req = 1'b0; rx_valid = 1'b0; rx_correct = 1'b0;
    check("t5_req_cpu", cpu_rst_n, 0);
    check("t5_req_loading", loading, 1);
    send(8'h00);
    check("t5_byte_dropped", load_error, 0);

    // 6: full 16-word load, hi[7:2] carries junk
    send(8'hA5); send(8'h10);
    chk = 8'h00;
    for (int i = 0; i < 16; i++) begin
      w  = 10'(i * 37);
      hb = {6'b101010, w[9:8]};
      chk = chk ^ w[7:0] ^ hb;
      send(w[7:0]); send(hb);
    end
    check("t6_pre_cpu", cpu_rst_n, 0);
    send(chk);
    check("t6_cpu", cpu_rst_n, 1);
    check("t6_loading", loading, 0);
    for (int i = 0; i < 16; i++) begin
      rd(4'(i), $sformatf("t6_mem%0d", i), 10'(i * 37));
    end

    // async reset mid-frame clears the memory
    req();
    send(8'hA5); send(8'h02); send(8'h77);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_loading", loading, 1);
    check("rst_mid_cpu", cpu_rst_n, 0);
    rd(4'd5, "rst_mid_mem5", 10'h000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
